// File: rtl/reg_write_arbiter_if.sv
// Bundles the two writeback requester handshakes with the register-file write port.
// The pending_mask signal exists only when PENDING_MASK_EN is defined.
`ifndef NUM_REGS_WIDTH
`define NUM_REGS_WIDTH 3
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif

interface reg_write_arbiter_if #(
  parameter int NUM_REGS_WIDTH = `NUM_REGS_WIDTH,
  parameter int REG_WIDTH      = `REG_WIDTH,
  parameter int CNT_WIDTH      = 8
);
  logic                      a_req;
  logic [NUM_REGS_WIDTH-1:0] a_rd;
  logic [REG_WIDTH-1:0]      a_data;
  logic                      a_gnt;
  logic                      b_req;
  logic [NUM_REGS_WIDTH-1:0] b_rd;
  logic [REG_WIDTH-1:0]      b_data;
  logic                      b_gnt;
  logic                      reg_write_en;
  logic [NUM_REGS_WIDTH-1:0] rd;
  logic [REG_WIDTH-1:0]      reg_in;
  logic [CNT_WIDTH-1:0]      conflict_cnt;
`ifdef PENDING_MASK_EN
  logic [(2**NUM_REGS_WIDTH)-1:0] pending_mask;
`endif

  // Requester / observer side
  modport master (
`ifdef PENDING_MASK_EN
    input  pending_mask,
`endif
    output a_req, a_rd, a_data, b_req, b_rd, b_data,
    input  a_gnt, b_gnt, reg_write_en, rd, reg_in, conflict_cnt
  );

  // Arbiter side
  modport slave (
`ifdef PENDING_MASK_EN
    output pending_mask,
`endif
    input  a_req, a_rd, a_data, b_req, b_rd, b_data,
    output a_gnt, b_gnt, reg_write_en, rd, reg_in, conflict_cnt
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between core
// writeback (A) and host/debug (B). Optional PENDING_MASK_EN adds an in-flight write mask.
`ifndef NUM_REGS_WIDTH
`define NUM_REGS_WIDTH 3
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif

module reg_write_arbiter #(
  parameter int NUM_REGS_WIDTH = `NUM_REGS_WIDTH,
  parameter int REG_WIDTH      = `REG_WIDTH,
  parameter int CNT_WIDTH      = 8
) (
  input logic               CLK,
  input logic               RST,
  reg_write_arbiter_if.slave bus
);

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } grant_t;

  grant_t                    last_grant;
  grant_t                    last_grant_next;
  logic                      a_gnt;
  logic                      b_gnt;
  logic                      write_en;
  logic [NUM_REGS_WIDTH-1:0] write_rd;
  logic [REG_WIDTH-1:0]      write_data;
  logic [CNT_WIDTH-1:0]      conflict_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant <= LAST_B;
    end else begin
      last_grant <= last_grant_next;
    end
  end

  // Grants are suppressed during reset so nothing transfers on the reset edge.
  always_comb begin
    a_gnt           = 1'b0;
    b_gnt           = 1'b0;
    last_grant_next = last_grant;
    if (!RST) begin
      if (bus.a_req && bus.b_req) begin
        if (last_grant == LAST_B) begin
          a_gnt = 1'b1;
        end else begin
          b_gnt = 1'b1;
        end
      end else if (bus.a_req) begin
        a_gnt = 1'b1;
      end else if (bus.b_req) begin
        b_gnt = 1'b1;
      end
    end
    if (a_gnt) begin
      last_grant_next = LAST_A;
    end else if (b_gnt) begin
      last_grant_next = LAST_B;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      write_en   <= 1'b0;
      write_rd   <= '0;
      write_data <= '0;
    end else if (a_gnt) begin
      write_en   <= 1'b1;
      write_rd   <= bus.a_rd;
      write_data <= bus.a_data;
    end else if (b_gnt) begin
      write_en   <= 1'b1;
      write_rd   <= bus.b_rd;
      write_data <= bus.b_data;
    end else begin
      write_en   <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      conflict_cnt <= '0;
    end else if (bus.a_req && bus.b_req && (conflict_cnt != {CNT_WIDTH{1'b1}})) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  assign bus.a_gnt        = a_gnt;
  assign bus.b_gnt        = b_gnt;
  assign bus.reg_write_en = write_en;
  assign bus.rd           = write_rd;
  assign bus.reg_in       = write_data;
  assign bus.conflict_cnt = conflict_cnt;

`ifdef PENDING_MASK_EN
  logic [(2**NUM_REGS_WIDTH)-1:0] pending_mask;

  always_comb begin
    pending_mask = '0;
    if (write_en) begin
      pending_mask[write_rd] = 1'b1;
    end
  end

  assign bus.pending_mask = pending_mask;
`endif

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the register file's single write port (reg_write_en / rd / reg_in) between two writeback requesters.
  - A: core writeback (ALU/load result).
  - B: host/debug write path.
- Round-robin arbitration with a req/gnt handshake; the winning request is registered and presented to the register file for exactly one cycle.
- Sits between the execute/writeback stages and the registers block; the register file's read ports are untouched.

Parameters:
- NUM_REGS_WIDTH, default `NUM_REGS_WIDTH (3): register index width.
- REG_WIDTH, default `REG_WIDTH (16): register data width.
- CNT_WIDTH, default 8: width of the saturating conflict counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- a_req  in  1  requester A wants a write.
- a_rd  in  NUM_REGS_WIDTH  A destination register.
- a_data  in  REG_WIDTH  A write data.
- a_gnt  out  1  A granted this cycle (combinational).
- b_req  in  1  requester B wants a write.
- b_rd  in  NUM_REGS_WIDTH  B destination register.
- b_data  in  REG_WIDTH  B write data.
- b_gnt  out  1  B granted this cycle (combinational).
- reg_write_en  out  1  write strobe to the register file (registered).
- rd  out  NUM_REGS_WIDTH  write index to the register file (registered).
- reg_in  out  REG_WIDTH  write data to the register file (registered).
- conflict_cnt  out  CNT_WIDTH  saturating count of cycles with both requests asserted.

Behaviour:
- Reset: clock and reset are one clock CLK and a synchronous, active-high RST, sampled on the rising edge of CLK.
  - Reset values: reg_write_en=0, rd=0, reg_in=0, conflict_cnt=0, last_grant=B (so A has priority first).
- Handshake:
  - A requester raises req with rd/data stable and holds all three until it sees gnt=1 at a rising edge.
  - Transfer occurs on an edge where req&gnt=1. The requester may drop req or present a new request the following cycle.
- Grant logic, combinational from req and last_grant:
  - Only A requesting -> a_gnt=1.
  - Only B requesting -> b_gnt=1.
  - Both requesting -> grant the one not equal to last_grant.
  - Neither requesting -> both gnt=0.
  - a_gnt and b_gnt are never both 1.
- last_grant updates on each transfer edge to the granted requester and holds otherwise.
- Output stage, latency 1:
  - On a transfer edge, reg_write_en<=1 and rd/reg_in take the granted requester's rd/data.
  - On a non-transfer edge, reg_write_en<=0 and rd/reg_in hold their last values.
  - The register file commits at the following edge, so data is visible on its read ports 2 edges after the transfer.
- Throughput: one write per cycle. Back-to-back grants alternate A,B,A,B while both requesters hold requests.
- Same rd from both requesters: the writes are serialised, and the later grant's data is final.
- conflict_cnt: increments on every edge where a_req&b_req=1 and saturates at all-ones (no wrap).
- Reset asserted mid-operation: any write in the output stage is dropped (reg_write_en=0 next cycle), and pending requests are not granted on the reset edge's outputs.
  - gnt is forced to 0 while RST=1.
- No special casing of register 0; the register file decides its semantics.

Optional Feature:
- Macro: PENDING_MASK_EN.
- Defined:
  - Adds output pending_mask, width 2**NUM_REGS_WIDTH, driven combinationally.
  - Bit i=1 when reg_write_en=1 and rd==i; all bits are 0 otherwise.
  - Decode hazard logic uses it to stall reads of a register whose write is in flight.
  - Reset value is all zeros.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- RST=1 for one edge, then RST=0, no requests -> a_gnt=b_gnt=0, reg_write_en=0, rd=0, reg_in=0, conflict_cnt=0.
- a_req=1, a_rd=2, a_data=16'h00A5 for one edge -> a_gnt=1 that cycle; next cycle reg_write_en=1, rd=2, reg_in=16'h00A5; the cycle after, reg_write_en=0.
- a_req=b_req=1 held for 4 edges, with A's data=1 and B's data=2 -> grant sequence A,B,A,B; reg_in sequence 1,2,1,2 one cycle later; conflict_cnt=4.
- A and B both target rd=5 with data 16'h1111 / 16'h2222 in the same cycle -> two consecutive writes: 16'h1111 then 16'h2222; register 5 ends at 16'h2222.
- Both requesting continuously for 300 cycles with CNT_WIDTH=8 -> conflict_cnt saturates at 255 and stays there.
- Transfer edge followed by RST=1 on the next edge -> reg_write_en=0 after the reset edge and gnt=0 during reset. With PENDING_MASK_EN, pending_mask=0 after reset and pending_mask=8'b0000_0100 while a write to rd=2 is in the output stage.
